shift_seq_ctrl: RTL and testbench

//  Multi-cycle shift sequencer: accepts one shift command (data, op, amount) over a

---
 rtl/shift_seq_ctrl_if.sv | 35 +++
 rtl/shift_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_shift_seq_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/shift_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl_if
// Command and result handshake bundle for the iterative shift sequencer.
//   in_valid / in_ready   : command handshake (issuer -> sequencer)
//   in_data / in_op / in_amt : operand, operation code, shift amount
//   out_valid / out_ready : result handshake (sequencer -> writeback)
//   out_data / out_err    : shifted result and unsupported-op flag
// Modports:
//   master : the command issuer / result consumer
//   slave  : the shift sequencer itself
// -----------------------------------------------------------------------------
interface shift_seq_ctrl_if #(
    parameter int W   = 4,
    parameter int SAW = 3
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic [1:0]     in_op;
    logic [SAW-1:0] in_amt;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           out_err;

    modport master (
        output in_valid, in_data, in_op, in_amt, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, in_op, in_amt, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface

// File: rtl/shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// shift_seq_ctrl
// Multi-cycle shift sequencer. Takes one command (data, op, amount), applies it
// one bit position per clock and returns the result over a valid/ready
// handshake. Replaces a wide combinational shifter with a small iterative path.
//
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : synchronous reset, active-low
//   bus    : shift_seq_ctrl_if.slave (command in / result out handshakes)
//   busy   : high while a command is in SHIFT or DONE
//
// Ops: 00 LSL, 01 LSR, 10 ASR (sign fill), 11 ROL.
//
// Build option: define SHIFT_ROTATE_EN to implement ROL. Without it, op 11
// completes after one cycle with the operand unchanged and out_err set, and
// no rotate logic is built.
// -----------------------------------------------------------------------------
module shift_seq_ctrl #(
    parameter int W   = 4,
    parameter int SAW = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_seq_ctrl_if.slave  bus,
    output logic             busy
);

    // Counter must be able to hold the value W (capped shift amount).
    localparam int CW = $clog2(W + 1);
    // Amount compare width wide enough for both in_amt and W, plus headroom.
    localparam int AW = ((SAW > CW) ? SAW : CW) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t         state_q,     state_d;
    logic [W-1:0]   work_q,      work_d;
    logic [CW-1:0]  cnt_q,       cnt_d;
    logic [1:0]     op_q,        op_d;
    logic           err_q,       err_d;
    logic           in_ready_q,  in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic           busy_q,      busy_d;

    logic [AW-1:0]  amt_ext_s;
    logic [CW-1:0]  amt_cap_s;

    // One-bit-position step of the working register for the given op.
    function automatic logic [W-1:0] shift_one(input logic [W-1:0] v,
                                               input logic [1:0]   op);
        logic [W-1:0] r;
        r = v;
        case (op)
            2'b00:   r = {v[W-2:0], 1'b0};
            2'b01:   r = {1'b0, v[W-1:1]};
            2'b10:   r = {v[W-1], v[W-1:1]};
`ifdef SHIFT_ROTATE_EN
            2'b11:   r = {v[W-2:0], v[W-1]};
`endif
            default: r = v;
        endcase
        return r;
    endfunction

    assign amt_ext_s = AW'(bus.in_amt);
    // Linear shifts saturate at W: shifting W or more times gives the same result.
    assign amt_cap_s = (amt_ext_s >= AW'(W)) ? CW'(W) : CW'(amt_ext_s);

`ifdef SHIFT_ROTATE_EN
    logic [CW-1:0]  amt_rol_s;
    // Rotation by a multiple of W is identity, so only the remainder matters.
    assign amt_rol_s = CW'(amt_ext_s % AW'(W));
`endif

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    work_d = bus.in_data;
                    op_d   = bus.in_op;
                    err_d  = 1'b0;
                    if (bus.in_op == 2'b11) begin
`ifdef SHIFT_ROTATE_EN
                        cnt_d = amt_rol_s;
`else
                        // Unsupported: pass operand through, flag the error.
                        cnt_d = CW'(0);
                        err_d = 1'b1;
`endif
                    end else begin
                        cnt_d = amt_cap_s;
                    end
                    state_d = (cnt_d != CW'(0)) ? ST_SHIFT : ST_DONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                work_d = shift_one(work_q, op_q);
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake flags are registered copies of the next-state decode.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            op_q        <= 2'b00;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // The working register doubles as the result register; it is only
    // reloaded on accept, so it keeps the last result while idle.
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = work_q;
    assign bus.out_err   = err_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shift_seq_ctrl
// Self-checking bench for shift_seq_ctrl: directed vector table, hand-written
// reset/backpressure sequences, and randomized commands against a behavioural
// model. Honours SHIFT_ROTATE_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_shift_seq_ctrl;

    localparam int W   = 4;
    localparam int SAW = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    int n_chk  = 0;
    int n_pass = 0;

    shift_seq_ctrl_if #(.W(W), .SAW(SAW)) bus ();

    shift_seq_ctrl #(.W(W), .SAW(SAW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] data;
        logic [1:0] op;
        logic [2:0] amt;
        logic [3:0] exp_data;
        logic       exp_err;
        int         exp_lat;
        int         hold;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: result from plain shift arithmetic, latency from the op rules.
    function automatic void model(input logic [3:0] d, input logic [1:0] op,
                                  input logic [2:0] amt, output logic [3:0] r,
                                  output logic e, output int lat);
        int a;
        int cnt;
        logic [7:0] t;
        a = int'(amt);
        e = 1'b0;
        case (op)
            2'b00: begin
                cnt = (a < W) ? a : W;
                t   = {4'b0000, d} << a;
                r   = (a >= W) ? 4'b0000 : t[3:0];
            end
            2'b01: begin
                cnt = (a < W) ? a : W;
                r   = d >> a;
            end
            2'b10: begin
                cnt = (a < W) ? a : W;
                r   = (a >= W) ? {W{d[W-1]}} : 4'($signed(d) >>> a);
            end
            default: begin
`ifdef SHIFT_ROTATE_EN
                cnt = a % W;
                t   = {d, d} >> (W - cnt);
                r   = t[3:0];
`else
                cnt = 0;
                r   = d;
                e   = 1'b1;
`endif
            end
        endcase
        lat = cnt + 1;
    endfunction

    // Issue one command, wait for the result, optionally stall, then consume it.
    task automatic run_cmd(input logic [3:0] d, input logic [1:0] op, input logic [2:0] amt,
                           input logic [3:0] er, input logic ee, input int el,
                           input int hold, input string tag);
        int w;
        int lat;
        w = 0;
        while (!bus.in_ready && w < 20) begin
            step();
            w++;
        end
        check({tag, " in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_op    = op;
        bus.in_amt   = amt;
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = 4'($urandom);
        bus.in_op    = 2'($urandom);
        bus.in_amt   = 3'($urandom);
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            bus.out_ready = 1'($urandom);
            step();
            lat++;
        end
        bus.out_ready = 1'b0;
        check({tag, " latency"},  32'(lat),          32'(el));
        check({tag, " out_data"}, 32'(bus.out_data), 32'(er));
        check({tag, " out_err"},  32'(bus.out_err),  32'(ee));
        check({tag, " busy_done"}, 32'(busy),        32'd1);
        check({tag, " in_ready_done"}, 32'(bus.in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            step();
            check({tag, " hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, " hold_data"},  32'(bus.out_data),  32'(er));
            check({tag, " hold_err"},   32'(bus.out_err),   32'(ee));
            check({tag, " hold_ready"}, 32'(bus.in_ready),  32'd0);
            check({tag, " hold_busy"},  32'(busy),          32'd1);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, " post_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, " post_ready"}, 32'(bus.in_ready),  32'd1);
        check({tag, " post_busy"},  32'(busy),          32'd0);
        check({tag, " post_data"},  32'(bus.out_data),  32'(er));
    endtask

    initial begin
        logic [3:0] r_d;
        logic       r_e;
        int         r_l;
        logic [3:0] rd;
        logic [1:0] rop;
        logic [2:0] ramt;
        int         stale;

        vecs[0] = '{4'b1011, 2'b10, 3'd1, 4'b1101, 1'b0, 2, 0};
        vecs[1] = '{4'b0011, 2'b00, 3'd2, 4'b1100, 1'b0, 3, 1};
        vecs[2] = '{4'b1100, 2'b01, 3'd5, 4'b0000, 1'b0, 5, 0};
        vecs[3] = '{4'b1000, 2'b10, 3'd7, 4'b1111, 1'b0, 5, 3};
        vecs[4] = '{4'b1010, 2'b00, 3'd0, 4'b1010, 1'b0, 1, 0};
        vecs[5] = '{4'b0110, 2'b10, 3'd0, 4'b0110, 1'b0, 1, 0};
        vecs[6] = '{4'b1001, 2'b10, 3'd4, 4'b1111, 1'b0, 5, 0};
        vecs[7] = '{4'b0001, 2'b00, 3'd3, 4'b1000, 1'b0, 4, 0};
        vecs[8] = '{4'b1001, 2'b01, 3'd3, 4'b0001, 1'b0, 4, 0};
`ifdef SHIFT_ROTATE_EN
        vecs[9]  = '{4'b1001, 2'b11, 3'd5, 4'b0011, 1'b0, 2, 0};
        vecs[10] = '{4'b0110, 2'b11, 3'd0, 4'b0110, 1'b0, 1, 0};
`else
        vecs[9]  = '{4'b1001, 2'b11, 3'd5, 4'b1001, 1'b1, 1, 0};
        vecs[10] = '{4'b0110, 2'b11, 3'd0, 4'b0110, 1'b1, 1, 0};
`endif

        bus.in_valid  = 1'b0;
        bus.in_data   = 4'b0000;
        bus.in_op     = 2'b00;
        bus.in_amt    = 3'd0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        step();
        step();
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst out_data",  32'(bus.out_data),  32'd0);
        check("rst out_err",   32'(bus.out_err),   32'd0);
        check("rst busy",      32'(busy),          32'd0);
        check("rst in_ready",  32'(bus.in_ready),  32'd1);
        rst_n = 1'b1;
        step();

        // Directed vector table.
        for (int i = 0; i < 11; i++) begin
            run_cmd(vecs[i].data, vecs[i].op, vecs[i].amt, vecs[i].exp_data,
                    vecs[i].exp_err, vecs[i].exp_lat, vecs[i].hold,
                    $sformatf("vec%0d", i));
        end

        // Reset during SHIFT discards the command.
        bus.in_valid = 1'b1;
        bus.in_data  = 4'b0011;
        bus.in_op    = 2'b00;
        bus.in_amt   = 3'd4;
        step();
        bus.in_valid = 1'b0;
        step();
        check("midrst busy_before", 32'(busy), 32'd1);
        check("midrst valid_before", 32'(bus.out_valid), 32'd0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrst out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst out_data",  32'(bus.out_data),  32'd0);
        check("midrst out_err",   32'(bus.out_err),   32'd0);
        check("midrst in_ready",  32'(bus.in_ready),  32'd1);
        check("midrst busy",      32'(busy),          32'd0);
        stale = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus.out_valid) stale++;
        end
        check("midrst no_stale", 32'(stale), 32'd0);
        run_cmd(4'b0101, 2'b01, 3'd1, 4'b0010, 1'b0, 2, 0, "after_rst");

        // Randomized commands against the behavioural model.
        for (int n = 0; n < 40; n++) begin
            rd   = 4'($urandom);
            rop  = 2'($urandom);
            ramt = 3'($urandom);
            model(rd, rop, ramt, r_d, r_e, r_l);
            run_cmd(rd, rop, ramt, r_d, r_e, r_l, int'($urandom_range(0, 2)),
                    $sformatf("rnd%0d op%0d d%0h a%0d", n, rop, rd, ramt));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
